max_scan_ctrl: RTL

Sequencing controller for the running-maximum score bank of the local-alignment datapath. Accepts a start pulse, clears the max bank, steps the compute array through `NUM_STEPS` anti-diagonal steps, and asserts `wr_en_max` only while valid scores reach the bank. It then drains the pipeline, captures the final max score/row/col, and offers them downstream on a valid/ready handshake.

---
 rtl/max_scan_ctrl_if.sv | 40 ++++
 rtl/max_scan_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/max_scan_ctrl_if.sv
// Bundle between the max-scan sequencer and its surroundings.
// Combinational wiring only, no latency.
// Result side uses valid/ready; the controller holds res_* until res_ready.
interface max_scan_ctrl_if #(
  parameter int SCORE_WIDTH    = 10,
  parameter int ROW_BITS_WIDTH = 6,
  parameter int COL_BITS_WIDTH = 6,
  parameter int STEP_WIDTH     = 6
);
  logic                      start;
  logic                      abort;
  logic                      busy;
  logic                      max_clr;
  logic                      step_en;
  logic [STEP_WIDTH-1:0]     step_idx;
  logic                      wr_en_max;
  logic [SCORE_WIDTH-1:0]    max_score_in;
  logic [ROW_BITS_WIDTH-1:0] max_row_in;
  logic [COL_BITS_WIDTH-1:0] max_col_in;
  logic                      res_valid;
  logic                      res_ready;
  logic [SCORE_WIDTH-1:0]    res_score;
  logic [ROW_BITS_WIDTH-1:0] res_row;
  logic [COL_BITS_WIDTH-1:0] res_col;
  logic                      res_zero;

  // Controller side.
  modport master (
    input  start, abort, max_score_in, max_row_in, max_col_in, res_ready,
    output busy, max_clr, step_en, step_idx, wr_en_max,
           res_valid, res_score, res_row, res_col, res_zero
  );

  // Datapath / consumer side.
  modport slave (
    output start, abort, max_score_in, max_row_in, max_col_in, res_ready,
    input  busy, max_clr, step_en, step_idx, wr_en_max,
           res_valid, res_score, res_row, res_col, res_zero
  );
endinterface

// File: rtl/max_scan_ctrl.sv
// Sequencer for the running-max score bank: clear, step, drain, settle, report.
// Start to first res_valid is NUM_STEPS+3+PIPE_LAT cycles.
// Result is held in REPORT until res_ready; abort returns to IDLE from any state.
module max_scan_ctrl #(
  parameter int NUM_STEPS      = 47,
  parameter int PIPE_LAT       = 2,
  parameter int SCORE_WIDTH    = 10,
  parameter int ROW_BITS_WIDTH = 6,
  parameter int COL_BITS_WIDTH = 6,
  parameter int STEP_WIDTH     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input logic           clk,
  input logic           rst_n,
  max_scan_ctrl_if.master bus
);

  localparam int DRAIN_WIDTH = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [STEP_WIDTH-1:0]  LAST_STEP  = STEP_WIDTH'(NUM_STEPS - 1);
  localparam logic [DRAIN_WIDTH-1:0] LAST_DRAIN = DRAIN_WIDTH'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    SETTLE,
    REPORT
  } state_t;

  state_t                    state;
  logic [STEP_WIDTH-1:0]     step_cnt;
  logic [DRAIN_WIDTH-1:0]    drain_cnt;
  logic [PIPE_LAT-1:0]       wr_pipe;
  logic [SCORE_WIDTH-1:0]    score_q;
  logic [ROW_BITS_WIDTH-1:0] row_q;
  logic [COL_BITS_WIDTH-1:0] col_q;
  logic                      zero_q;

  // Sequencer: walks the alignment phases; abort wins over everything outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_cnt  <= '0;
      drain_cnt <= '0;
    end else if (bus.abort && state != IDLE) begin
      state     <= IDLE;
      step_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= CLEAR;
        end
        CLEAR: begin
          state    <= RUN;
          step_cnt <= '0;
        end
        RUN: begin
          if (step_cnt == LAST_STEP) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            step_cnt <= step_cnt + STEP_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == LAST_DRAIN) state <= SETTLE;
          else drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
        end
        SETTLE: begin
          state <= REPORT;
        end
        REPORT: begin
          if (bus.res_ready) begin
            state    <= IDLE;
            step_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Delay line matching the compute pipeline: a step's scores reach the bank PIPE_LAT cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pipe <= '0;
    end else if (state == IDLE || state == CLEAR || bus.abort) begin
      wr_pipe <= '0;
    end else begin
      wr_pipe <= PIPE_LAT'({wr_pipe, (state == RUN)});
    end
  end

  // Capture the settled bank contents as SETTLE ends; an aborted run leaves the old result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      zero_q  <= 1'b0;
    end else if (state == SETTLE && !bus.abort) begin
      score_q <= bus.max_score_in;
      row_q   <= bus.max_row_in;
      col_q   <= bus.max_col_in;
      zero_q  <= (bus.max_score_in == '0);
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.max_clr   = (state == CLEAR);
  assign bus.step_en   = (state == RUN);
  assign bus.res_valid = (state == REPORT);
  assign bus.step_idx  = step_cnt;
  assign bus.wr_en_max = wr_pipe[PIPE_LAT-1];
  assign bus.res_score = score_q;
  assign bus.res_row   = row_q;
  assign bus.res_col   = col_q;
  assign bus.res_zero  = zero_q;

endmodule
